jt8255_hsbridge: RTL and testbench

Peripheral-side handshake bridge for one jt8255 port running in mode 1 or mode 2. It sits directly downstream of the PPI port pins. It delivers bytes from a system-side stream into the PPI input latch using STB/IBF, and drains bytes the CPU wrote to the PPI output latch using OBF/ACK. Each direction has a small FIFO, so game-side logic (sound latch, MCU link) never stalls on CPU timing.

---
 rtl/jt8255_hsbridge.sv | 167 ++++++++++++++++
 tb/tb_jt8255_hsbridge.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt8255_hsbridge.sv
// Peripheral-side handshake bridge for one jt8255 port in mode 1/2.
// A TX FIFO feeds the PPI input latch via STB/IBF; an RX FIFO drains the output latch via OBF/ACK.
module jt8255_hsbridge #(
    parameter int AW      = 2,
    parameter int STB_LEN = 4,
    parameter int ACK_LEN = 4
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          tx_en,
    input  logic          rx_en,
    input  logic [7:0]    tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [AW:0]   tx_level,
    output logic [AW:0]   rx_level,
    output logic [7:0]    ppi_din,
    input  logic [7:0]    ppi_dout,
    input  logic          ibf,
    input  logic          obf_n,
    output logic          stb,
    output logic          ack
);
    localparam int          DEPTH    = 1 << AW;
    localparam int          LEN_MAX  = (STB_LEN > ACK_LEN) ? STB_LEN : ACK_LEN;
    localparam int          CW       = $clog2(LEN_MAX + 1);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_STROBE, TX_WAIT_IBF} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT_OBF} rx_state_t;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    tx_state_t     tx_state, tx_state_nx;
    rx_state_t     rx_state, rx_state_nx;
    logic [CW-1:0] tx_cnt, tx_cnt_nx, rx_cnt, rx_cnt_nx;
    logic          stb_nx, ack_nx;
    logic [7:0]    din_nx;

    // A full TX FIFO still accepts a byte in the cycle the FSM takes the head.
    assign tx_ready = (tx_level != LVL_FULL) || tx_pop;
    assign tx_push  = tx_valid && tx_ready;
    assign rx_valid = (rx_level != '0);
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_data  = rx_mem[rx_rd];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= tx_data;
        if (rx_push) rx_mem[rx_wr] <= ppi_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_level <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_level <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            if (tx_push && !tx_pop)      tx_level <= tx_level + (AW+1)'(1);
            else if (!tx_push && tx_pop) tx_level <= tx_level - (AW+1)'(1);
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            if (rx_push && !rx_pop)      rx_level <= rx_level + (AW+1)'(1);
            else if (!rx_push && rx_pop) rx_level <= rx_level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            stb      <= 1'b0;
            ack      <= 1'b0;
            ppi_din  <= 8'hff;
        end else begin
            tx_state <= tx_state_nx;
            rx_state <= rx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            rx_cnt   <= rx_cnt_nx;
            stb      <= stb_nx;
            ack      <= ack_nx;
            ppi_din  <= din_nx;
        end
    end

    // WAIT_IBF absorbs the PPI's delayed IBF update so a byte is never strobed twice.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        stb_nx      = stb;
        din_nx      = ppi_din;
        tx_pop      = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_en && (tx_level != '0) && !ibf) begin
                    din_nx      = tx_mem[tx_rd];
                    tx_pop      = 1'b1;
                    tx_state_nx = TX_SETUP;
                end
            end
            TX_SETUP: begin
                stb_nx      = 1'b1;
                tx_cnt_nx   = CW'(STB_LEN - 1);
                tx_state_nx = TX_STROBE;
            end
            TX_STROBE: begin
                if (tx_cnt == '0) begin
                    stb_nx      = 1'b0;
                    tx_state_nx = TX_WAIT_IBF;
                end else begin
                    tx_cnt_nx = tx_cnt - CW'(1);
                end
            end
            TX_WAIT_IBF: begin
                if (ibf) tx_state_nx = TX_IDLE;
            end
            default: begin
                stb_nx      = 1'b0;
                tx_state_nx = TX_IDLE;
            end
        endcase
    end

    // A full RX FIFO leaves OBF asserted, which back-pressures the CPU.
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        ack_nx      = ack;
        rx_push     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_en && !obf_n && (rx_level != LVL_FULL)) begin
                    rx_push     = 1'b1;
                    ack_nx      = 1'b1;
                    rx_cnt_nx   = CW'(ACK_LEN - 1);
                    rx_state_nx = RX_ACK;
                end
            end
            RX_ACK: begin
                if (rx_cnt == '0) begin
                    ack_nx      = 1'b0;
                    rx_state_nx = RX_WAIT_OBF;
                end else begin
                    rx_cnt_nx = rx_cnt - CW'(1);
                end
            end
            RX_WAIT_OBF: begin
                if (obf_n) rx_state_nx = RX_IDLE;
            end
            default: begin
                ack_nx      = 1'b0;
                rx_state_nx = RX_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_jt8255_hsbridge.sv
// Self-checking bench for jt8255_hsbridge: directed handshake scenarios plus a
// randomized soak against a queue-based model of the PPI and both FIFOs.
module tb_jt8255_hsbridge;
    localparam int AW      = 2;
    localparam int DEPTH   = 1 << AW;
    localparam int STB_LEN = 4;
    localparam int ACK_LEN = 4;
    localparam int SOAK_N  = 60;

    logic          rst, clk, tx_en, rx_en, tx_valid, tx_ready;
    logic          rx_valid, rx_ready, ibf, obf_n, stb, ack;
    logic [7:0]    tx_data, rx_data, ppi_din, ppi_dout;
    logic [AW:0]   tx_level, rx_level;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [7:0]    tx_model [$];
    logic [7:0]    rx_model [$];

    jt8255_hsbridge #(.AW(AW), .STB_LEN(STB_LEN), .ACK_LEN(ACK_LEN)) dut (
        .rst      (rst),
        .clk      (clk),
        .tx_en    (tx_en),
        .rx_en    (rx_en),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_level (tx_level),
        .rx_level (rx_level),
        .ppi_din  (ppi_din),
        .ppi_dout (ppi_dout),
        .ibf      (ibf),
        .obf_n    (obf_n),
        .stb      (stb),
        .ack      (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pushTx(input logic [7:0] b);
        checkOutput("tx_ready_before_push", 32'(tx_ready), 1);
        tx_data  = b;
        tx_valid = 1'b1;
        applyStimulus(1);
        tx_valid = 1'b0;
        tx_model.push_back(b);
    endtask

    // Waits for a strobe, plays the PPI raising IBF, and holds IBF for 'hold' cycles.
    task automatic expectStrobe(input int hold);
        logic [7:0] exp_b;
        int         t, w;
        logic       din_ok;
        exp_b = 8'hxx;
        if (tx_model.size() > 0) exp_b = tx_model.pop_front();
        t = 0;
        while (stb !== 1'b1 && t < 40) begin
            applyStimulus(1);
            t++;
        end
        checkOutput("stb_rise", 32'(stb), 1);
        checkOutput("ppi_din_at_stb", 32'(ppi_din), 32'(exp_b));
        checkOutput("tx_level_at_stb", 32'(tx_level), tx_model.size());
        ibf    = 1'b1;
        w      = 1;
        din_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            applyStimulus(1);
            if (stb === 1'b1) w++;
            if (ppi_din !== exp_b) din_ok = 1'b0;
        end
        checkOutput("stb_width", w, STB_LEN);
        checkOutput("ppi_din_held_while_ibf", 32'(din_ok), 1);
        ibf = 1'b0;
    endtask

    // Plays a CPU write into the PPI output latch and waits for the ack pulse.
    task automatic offerRx(input logic [7:0] b, input int watch, output int lat);
        int w;
        ppi_dout = b;
        obf_n    = 1'b0;
        lat      = 0;
        do begin
            applyStimulus(1);
            lat++;
        end while (ack !== 1'b1 && lat < 40);
        checkOutput("ack_rise", 32'(ack), 1);
        rx_model.push_back(b);
        checkOutput("rx_level_at_ack", 32'(rx_level), rx_model.size());
        checkOutput("rx_valid_at_ack", 32'(rx_valid), 1);
        obf_n = 1'b1;
        w     = 1;
        for (int i = 0; i < watch; i++) begin
            applyStimulus(1);
            if (ack === 1'b1) w++;
        end
        checkOutput("ack_width", w, ACK_LEN);
        checkOutput("rx_level_no_recapture", 32'(rx_level), rx_model.size());
    endtask

    task automatic popRx();
        logic [7:0] exp_b;
        exp_b = 8'hxx;
        if (rx_model.size() > 0) exp_b = rx_model.pop_front();
        checkOutput("rx_valid_before_pop", 32'(rx_valid), 1);
        checkOutput("rx_data_head", 32'(rx_data), 32'(exp_b));
        rx_ready = 1'b1;
        applyStimulus(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b, latched, exp_b;
        int         lat, cnt, t, pushed, written, ibf_timer, obf_gap;
        logic       prev_stb, prev_ack;

        rst = 1'b1; tx_en = 1'b0; rx_en = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        rx_ready = 1'b0; ppi_dout = 8'h00; ibf = 1'b0; obf_n = 1'b1;
        applyStimulus(2);
        checkOutput("reset_stb", 32'(stb), 0);
        checkOutput("reset_ack", 32'(ack), 0);
        checkOutput("reset_ppi_din", 32'(ppi_din), 'hff);
        checkOutput("reset_tx_ready", 32'(tx_ready), 1);
        checkOutput("reset_rx_valid", 32'(rx_valid), 0);
        checkOutput("reset_tx_level", 32'(tx_level), 0);
        checkOutput("reset_rx_level", 32'(rx_level), 0);
        rst   = 1'b0;
        tx_en = 1'b1;
        applyStimulus(1);

        $display("[TB] single TX byte latency");
        pushTx(8'h5A);
        checkOutput("tx_level_edge0", 32'(tx_level), 1);
        applyStimulus(1);
        checkOutput("ppi_din_edge1", 32'(ppi_din), 'h5A);
        checkOutput("stb_low_edge1", 32'(stb), 0);
        checkOutput("tx_level_edge1", 32'(tx_level), 0);
        applyStimulus(1);
        checkOutput("stb_high_edge2", 32'(stb), 1);
        expectStrobe(10);

        $display("[TB] TX burst behind a busy input latch");
        ibf = 1'b1;
        pushTx(8'h11);
        pushTx(8'h22);
        pushTx(8'h33);
        checkOutput("tx_level_three", 32'(tx_level), 3);
        applyStimulus(5);
        checkOutput("ppi_din_parked", 32'(ppi_din), 'h5A);
        checkOutput("stb_parked", 32'(stb), 0);
        ibf = 1'b0;
        for (int i = 0; i < 3; i++) expectStrobe(20);
        checkOutput("tx_level_drained", 32'(tx_level), 0);

        $display("[TB] single RX capture");
        tx_en = 1'b0;
        rx_en = 1'b1;
        offerRx(8'hC3, ACK_LEN + 8, lat);
        checkOutput("ack_latency", lat, 1);
        popRx();
        checkOutput("rx_valid_after_pop", 32'(rx_valid), 0);

        $display("[TB] RX back-pressure when full");
        for (int i = 0; i < DEPTH; i++) offerRx(8'($urandom), ACK_LEN + 4, lat);
        checkOutput("rx_level_full", 32'(rx_level), DEPTH);
        b        = 8'($urandom);
        ppi_dout = b;
        obf_n    = 1'b0;
        cnt      = 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1);
            if (ack === 1'b1) cnt++;
        end
        checkOutput("ack_held_low_when_full", cnt, 0);
        checkOutput("rx_level_still_full", 32'(rx_level), DEPTH);
        popRx();
        offerRx(b, ACK_LEN + 10, lat);
        checkOutput("ack_latency_after_pop", lat, 1);
        for (int i = 0; i < DEPTH; i++) popRx();
        checkOutput("rx_level_empty", 32'(rx_level), 0);

        $display("[TB] TX push and pop on a full FIFO");
        rx_en = 1'b0;
        tx_en = 1'b1;
        ibf   = 1'b1;
        for (int i = 0; i < DEPTH; i++) pushTx(8'($urandom));
        checkOutput("tx_level_full", 32'(tx_level), DEPTH);
        checkOutput("tx_ready_full", 32'(tx_ready), 0);
        b        = 8'($urandom);
        ibf      = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        #1;
        checkOutput("tx_ready_full_with_pop", 32'(tx_ready), 1);
        applyStimulus(1);
        tx_valid = 1'b0;
        tx_model.push_back(b);
        checkOutput("tx_level_push_pop_full", 32'(tx_level), DEPTH);
        for (int i = 0; i < DEPTH + 1; i++) expectStrobe(12);

        $display("[TB] asynchronous reset during strobe");
        ibf = 1'b1;
        pushTx(8'($urandom));
        pushTx(8'($urandom));
        ibf = 1'b0;
        t   = 0;
        while (stb !== 1'b1 && t < 40) begin
            applyStimulus(1);
            t++;
        end
        checkOutput("stb_before_reset", 32'(stb), 1);
        checkOutput("tx_level_before_reset", 32'(tx_level), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("stb_async_reset", 32'(stb), 0);
        checkOutput("ppi_din_async_reset", 32'(ppi_din), 'hff);
        checkOutput("tx_level_async_reset", 32'(tx_level), 0);
        applyStimulus(1);
        rst = 1'b0;
        tx_model.delete();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1);
            if (stb === 1'b1) cnt++;
        end
        checkOutput("no_strobe_after_reset", cnt, 0);
        checkOutput("ppi_din_after_reset", 32'(ppi_din), 'hff);

        $display("[TB] randomized soak with both directions enabled");
        rx_en     = 1'b1;
        pushed    = 0;
        written   = 0;
        ibf_timer = 0;
        obf_gap   = 0;
        latched   = 8'h00;
        prev_stb  = stb;
        prev_ack  = ack;
        rx_model.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus(1);
            if (stb === 1'b1 && prev_stb === 1'b0) begin
                exp_b = 8'hxx;
                if (tx_model.size() > 0) exp_b = tx_model.pop_front();
                checkOutput("soak_tx_order", 32'(ppi_din), 32'(exp_b));
                latched   = ppi_din;
                ibf       = 1'b1;
                ibf_timer = STB_LEN + 2 + int'($urandom_range(0, 6));
            end else if (ibf_timer > 0) begin
                ibf_timer--;
                if (ibf_timer == 0) begin
                    checkOutput("soak_din_held", 32'(ppi_din), 32'(latched));
                    ibf = 1'b0;
                end
            end
            if (ack === 1'b1 && prev_ack === 1'b0) begin
                rx_model.push_back(ppi_dout);
                obf_n   = 1'b1;
                obf_gap = ACK_LEN + 2;
            end else if (obf_gap > 0) begin
                obf_gap--;
            end else if (obf_n && written < SOAK_N && $urandom_range(0, 3) == 0) begin
                ppi_dout = 8'($urandom);
                obf_n    = 1'b0;
                written++;
            end
            prev_stb = stb;
            prev_ack = ack;
            tx_valid = (pushed < SOAK_N) && ($urandom_range(0, 2) != 0);
            tx_data  = 8'($urandom);
            rx_ready = ($urandom_range(0, 2) == 0);
            #1;
            if (tx_valid && tx_ready) begin
                tx_model.push_back(tx_data);
                pushed++;
            end
            if (rx_valid && rx_ready) begin
                exp_b = 8'hxx;
                if (rx_model.size() > 0) exp_b = rx_model.pop_front();
                checkOutput("soak_rx_order", 32'(rx_data), 32'(exp_b));
            end
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        checkOutput("soak_all_pushed", pushed, SOAK_N);
        checkOutput("soak_all_written", written, SOAK_N);
        checkOutput("soak_tx_model_empty", tx_model.size(), 0);
        checkOutput("soak_rx_model_empty", rx_model.size(), 0);
        checkOutput("soak_tx_level_zero", 32'(tx_level), 0);
        checkOutput("soak_rx_level_zero", 32'(rx_level), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
